// File: rtl/seq_uart_tx_pkg.sv
// Shared definitions for the sequencer UART transmitter: state encoding and default width.
package seq_uart_tx_pkg;

    // Matches the sequencer datapath width.
    localparam int unsigned SEQ_DP_WIDTH = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/seq_uart_tx_baud_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1 while enabled, restarts from 0 on clear.
module seq_uart_tx_baud_gen #(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt_q;

    // pre_tick marks the cycle before the bit boundary so callers can register edge-aligned pulses.
    assign tick_c     = en && (cnt_q == CNT_LAST);
    assign pre_tick_c = en && (cnt_q == CNT_PRE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit(s).
module seq_uart_tx
    import seq_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SEQ_DP_WIDTH,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_busy,
    output logic                  o_tx,
    output logic                  o_tx_done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic ODD_INV = (PARITY_ODD != 0);
    localparam logic HAS_PARITY = (PARITY_EN != 0);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept_c;
    logic baud_en_c;
    logic tick_c;
    logic pre_tick_c;

    assign accept_c  = i_tx_valid && !busy_q;
    assign baud_en_c = (state_q != TX_IDLE);

    seq_uart_tx_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_c),
        .en        (baud_en_c),
        .tick_c    (tick_c),
        .pre_tick_c(pre_tick_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic; tx/busy/done are the registered versions of these.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept_c) begin
                    state_d   = TX_START;
                    shift_d   = i_tx_data;
                    parity_d  = (^i_tx_data) ^ ODD_INV;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            TX_START: begin
                if (tick_c) begin
                    state_d   = TX_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            TX_DATA: begin
                if (tick_c) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (HAS_PARITY) begin
                            state_d = TX_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = TX_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick_c) begin
                    state_d   = TX_STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                // Done is registered one cycle early so it lands on the last stop-bit cycle.
                if (pre_tick_c && (bit_cnt_q == LAST_STOP)) begin
                    done_d = 1'b1;
                end
                if (tick_c) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = TX_IDLE;
                        bit_cnt_d = '0;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset forces the line high immediately, abandoning any frame without a low glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

endmodule
